// File: rtl/tanh_pkg.sv
// Shared constants and helpers for the tanh piecewise-linear activation blocks.
// Values use signed Q2.(WIDTH-2) format, so ONE = 1 << (WIDTH-2).
package tanh_pkg;

  // Per-sample mode encoding; code 3 behaves like MODE_EXACT
  localparam logic [1:0] MODE_EXACT  = 2'd0;
  localparam logic [1:0] MODE_APPROX = 2'd1;
  localparam logic [1:0] MODE_CLAMP  = 2'd2;

  // Unity in Q2.(width-2)
  function automatic int seg_one(input int width);
    return 32'sd1 <<< (width - 32'sd2);
  endfunction

  // End of the identity segment: 0.5 * ONE
  function automatic int seg_lin_th(input int width);
    return seg_one(width) >>> 32'sd1;
  endfunction

  // Start of the saturated segment: 1.5 * ONE
  function automatic int seg_sat_th(input int width);
    return seg_one(width) + (seg_one(width) >>> 32'sd1);
  endfunction

endpackage

// File: rtl/tanh_pwl_core.sv
// Combinational three-segment tanh magnitude approximation.
// Takes |x| in WIDTH+1 bits (so |-2.0| is representable) and returns a
// magnitude in [0, ONE], which always fits in WIDTH bits.
module tanh_pwl_core
  import tanh_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   mag,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] m
);

  localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(seg_one(WIDTH));
  localparam logic [WIDTH:0] TH_LIN = (WIDTH+1)'(seg_lin_th(WIDTH));
  localparam logic [WIDTH:0] TH_SAT = (WIDTH+1)'(seg_sat_th(WIDTH));

  // Segment select: clamp-only mode is min(|x|, ONE); otherwise identity, half-slope, or saturate
  always_comb begin
    m = '0;
    if (mode == MODE_CLAMP) begin
      if (mag > ONE_W) begin
        m = WIDTH'(ONE_W);
      end else begin
        m = WIDTH'(mag);
      end
    end else begin
      if (mag < TH_LIN) begin
        m = WIDTH'(mag);
      end else if (mag < TH_SAT) begin
        m = WIDTH'((mag >> 1) + (ONE_W >> 2));
      end else begin
        m = WIDTH'(ONE_W);
      end
    end
  end

endmodule

// File: rtl/tanh_pwl_pipe.sv
// Three-stage valid/ready pipeline computing a piecewise-linear tanh.
// Stage 1: sign and |x|; stage 2: segment magnitude; stage 3: optional LSB
// truncation and sign restore. Each stage holds while the next is stalled.
module tanh_pwl_pipe
  import tanh_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_LSBS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      sat_count
);

  localparam logic [WIDTH:0]   TH_SAT      = (WIDTH+1)'(seg_sat_th(WIDTH));
  localparam logic [WIDTH-1:0] APPROX_MASK = ~WIDTH'((32'd1 << APPROX_LSBS) - 32'd1);

  logic             s1_valid;
  logic             s1_sign;
  logic [WIDTH:0]   s1_mag;
  logic [1:0]       s1_mode;
  logic             s2_valid;
  logic             s2_sign;
  logic             s2_approx;
  logic [WIDTH-1:0] s2_m;

  logic             s1_ready;
  logic             s2_ready;
  logic             s3_ready;
  logic             in_fire;
  logic [WIDTH:0]   in_ext;
  logic [WIDTH:0]   in_mag;
  logic [WIDTH-1:0] core_m;
  logic [WIDTH-1:0] m_mask;
  logic [WIDTH-1:0] y_next;

  // A stage may load when it is empty or its content moves on this cycle
  assign s3_ready = ~out_valid | out_ready;
  assign s2_ready = ~s2_valid | s3_ready;
  assign s1_ready = ~s1_valid | s2_ready;
  assign in_ready = s1_ready;
  assign in_fire  = in_valid & in_ready;

  // Sign-extend before negating so -2.0 becomes +2.0 rather than wrapping
  assign in_ext = {in_data[WIDTH-1], in_data};
  assign in_mag = in_data[WIDTH-1] ? (-in_ext) : in_ext;

  // Stage 1: capture sign, widened magnitude and the sample's mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_mode  <= MODE_EXACT;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_data[WIDTH-1];
        s1_mag  <= in_mag;
        s1_mode <= in_mode;
      end
    end
  end

  tanh_pwl_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .mag  (s1_mag),
    .mode (s1_mode),
    .m    (core_m)
  );

  // Stage 2: register the segment magnitude; only the approx flag of the mode is still needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_approx <= 1'b0;
      s2_m      <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign   <= s1_sign;
        s2_approx <= (s1_mode == MODE_APPROX);
        s2_m      <= core_m;
      end
    end
  end

  // Truncate magnitude in approx mode, then restore sign (symmetric about zero)
  always_comb begin
    m_mask = s2_m;
    y_next = '0;
    if (s2_approx) begin
      m_mask = s2_m & APPROX_MASK;
    end else begin
      m_mask = s2_m;
    end
    if (s2_sign) begin
      y_next = -m_mask;
    end else begin
      y_next = m_mask;
    end
  end

  // Stage 3: registered output, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s3_ready) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= y_next;
      end
    end
  end

  // Saturating count of accepted samples at or beyond the saturation threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= 16'd0;
    end else if (in_fire && (in_mag >= TH_SAT) && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tanh_pwl_pipe.sv
// Directed self-checking bench for tanh_pwl_pipe (WIDTH=8, APPROX_LSBS=2, ONE=64).
`timescale 1ns/1ps
module tb_tanh_pwl_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [15:0] sat_count;

  int tests_run;
  int tests_failed;

  logic [7:0] sx[$];
  logic [1:0] sm[$];
  logic [7:0] rx[$];
  bit         saw_block;

  tanh_pwl_pipe #(
    .WIDTH       (8),
    .APPROX_LSBS (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_mode   = 2'd0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One isolated sample: no output before the third cycle, correct value on it
  task automatic check_one(input string name, input logic [7:0] x,
                           input logic [1:0] mode, input logic [7:0] exp_y);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = x;
    in_mode   = mode;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~x;
    in_mode  = ~mode;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s early_valid_c1: got %b want 0", name, out_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s early_valid_c2: got %b want 0", name, out_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if ((out_valid !== 1'b1) || (out_data !== exp_y)) begin
      tests_failed++;
      $display("FAIL %s result: got valid=%b y=%0d want valid=1 y=%0d",
               name, out_valid, $signed(out_data), $signed(exp_y));
    end
  endtask

  // Stream driver: sends sx/sm, collects accepted outputs into rx; no checks here
  task automatic run_stream(input int stall_from, input int stall_len);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    rx.delete();
    saw_block = 1'b0;
    while ((rx.size() < sx.size()) && (cyc < 200)) begin
      @(posedge clk); #1;
      out_ready = !((cyc >= stall_from) && (cyc < stall_from + stall_len));
      if (idx < sx.size()) begin
        in_valid = 1'b1;
        in_data  = sx[idx];
        in_mode  = sm[idx];
      end else begin
        in_valid = 1'b0;
        in_mode  = 2'd0;
      end
      #1;
      if (!out_ready && out_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) rx.push_back(out_data);
      cyc++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_mode   = 2'd0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #12;
    tests_run++;
    if ((out_valid !== 1'b0) || (out_data !== 8'd0) || (sat_count !== 16'd0)) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b y=%0d sat=%0d want 0 0 0",
               out_valid, out_data, sat_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_exact;
    check_one("exact_16",  8'd16,  2'd0, 8'd16);
    check_one("exact_32",  8'd32,  2'd0, 8'd32);
    check_one("exact_64",  8'd64,  2'd0, 8'd48);
    check_one("exact_96",  8'd96,  2'd0, 8'd64);
    check_one("exact_100", 8'd100, 2'd0, 8'd64);
  endtask

  task automatic test_negative_and_approx;
    check_one("exact_m128",  8'h80, 2'd0, 8'hC0);   // -128 -> -64
    check_one("exact_m45",   8'hD3, 2'd0, 8'hDA);   // -45 -> -38
    check_one("approx_45",   8'd45, 2'd1, 8'd36);
    check_one("approx_m45",  8'hD3, 2'd1, 8'hDC);   // -45 -> -36
    check_one("mode3_64",    8'd64, 2'd3, 8'd48);
  endtask

  task automatic test_clamp;
    check_one("clamp_50",   8'd50, 2'd2, 8'd50);
    check_one("clamp_m100", 8'h9C, 2'd2, 8'hC0);    // -100 -> -64
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    sx.delete(); sm.delete();
    sx = '{8'd45, 8'd45, 8'hD3, 8'd50, 8'd127, 8'd20};
    sm = '{2'd1,  2'd0,  2'd1,  2'd2,  2'd2,   2'd1};
    exp_q = '{8'd36, 8'd38, 8'hDC, 8'd50, 8'd64, 8'd20};
    run_stream(1000, 0);
    tests_run++;
    if (rx.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d want %0d", rx.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (rx[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL b2b_item%0d: got %0d want %0d", i, $signed(rx[i]), $signed(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_stall;
    sx.delete(); sm.delete();
    for (int i = 1; i <= 12; i++) begin
      sx.push_back(8'(2 * i));
      sm.push_back(2'd0);
    end
    run_stream(3, 5);
    tests_run++;
    if (saw_block !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_in_ready_low: got %b want 1", saw_block);
    end
    tests_run++;
    if (rx.size() != 12) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d want 12", rx.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        tests_run++;
        if (rx[i] !== 8'(2 * (i + 1))) begin
          tests_failed++;
          $display("FAIL stall_order%0d: got %0d want %0d", i, rx[i], 2 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_sat;
    int n;
    int cyc;
    apply_reset();
    n = 0;
    cyc = 0;
    while ((n < 65540) && (cyc < 70000)) begin
      @(posedge clk); #1;
      if (n == 65534) begin
        tests_run++;
        if (sat_count !== 16'hFFFE) begin
          tests_failed++;
          $display("FAIL sat_65534: got %h want fffe", sat_count);
        end
      end
      if (n == 65535) begin
        tests_run++;
        if (sat_count !== 16'hFFFF) begin
          tests_failed++;
          $display("FAIL sat_65535: got %h want ffff", sat_count);
        end
      end
      in_valid = 1'b1;
      in_data  = 8'd127;
      in_mode  = 2'd0;
      #1;
      if (in_ready) n++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (n != 65540) begin
      tests_failed++;
      $display("FAIL sat_transfers: got %0d want 65540", n);
    end
    tests_run++;
    if (sat_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sat_final: got %h want ffff", sat_count);
    end
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (sat_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sat_stable: got %h want ffff", sat_count);
    end
  endtask

  task automatic test_midflight_reset;
    bit stale;
    apply_reset();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'd100; in_mode = 2'd0;
    @(posedge clk); #1;
    in_data = 8'h80;
    @(posedge clk); #1;
    in_data = 8'd127;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if ((sat_count !== 16'd3) || (out_valid !== 1'b1)) begin
      tests_failed++;
      $display("FAIL midrst_before: got sat=%0d valid=%b want 3 1", sat_count, out_valid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ((out_valid !== 1'b0) || (sat_count !== 16'd0) || (out_data !== 8'd0)) begin
      tests_failed++;
      $display("FAIL midrst_during: got valid=%b sat=%0d y=%0d want 0 0 0",
               out_valid, sat_count, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    tests_run++;
    if (stale) begin
      tests_failed++;
      $display("FAIL midrst_stale: got stale output=1 want 0");
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_in_ready: got %b want 1", in_ready);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_exact();
    test_negative_and_approx();
    test_clamp();
    test_back_to_back();
    test_stall();
    test_midflight_reset();
    test_sat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tanh_pwl_pipe.md
TANH_PWL_PIPE -- requirements
Module: tanh_pwl_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in signed Q2.(WIDTH-2) format, legal range 4..16.
REQ-002 SHALL have parameter APPROX_LSBS, default 2: number of magnitude LSBs cleared in approximate mode, legal range 0..WIDTH-3.
REQ-003 SHALL have port clk, input, 1: single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1: input sample valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-007 SHALL have port in_data, input, WIDTH: signed input x.
REQ-008 SHALL have port in_mode, input, 2: per-sample mode (0 PWL exact, 1 PWL approximate, 2 clamp-only, 3 treated as 0).
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-011 SHALL have port out_data, output, WIDTH: signed result y.
REQ-012 SHALL have port sat_count, output, 16: count of accepted samples with |x| >= 1.5.

Function
REQ-013 Handshake: transfer on valid&ready at each port; in_ready SHALL equal (~out_valid | out_ready) | any pipeline bubble; a valid stage SHALL hold its data while stalled.
REQ-014 Latency SHALL be exactly 3 cycles from input transfer to out_valid when not stalled; throughput 1 sample/cycle.
REQ-015 Mode SHALL be captured with its sample and travel through the pipeline; changing in_mode between samples SHALL not affect samples in flight.
REQ-016 Stage 1 SHALL register the sign and |x| computed in WIDTH+1 bits, so that x = -2.0 yields |x| = 2.0 without overflow.
REQ-017 Stage 2 SHALL compute magnitude m (ONE = 1<<(WIDTH-2)): |x| < 0.5 gives m = |x|; 0.5 <= |x| < 1.5 gives m = (|x|>>1) + (ONE>>2), using floor shift; |x| >= 1.5 gives m = ONE.
REQ-018 Mode 2 SHALL give m = min(|x|, ONE).
REQ-019 Stage 3 SHALL, in mode 1 only, clear the APPROX_LSBS LSBs of m, then output y = sign ? -m : m; the result is symmetric, f(-x) = -f(x) exactly.
REQ-020 out_data SHALL always lie in [-ONE, ONE]; no wrap-around SHALL occur for any input.
REQ-021 sat_count SHALL increment by 1 on each input transfer with |x| >= 1.5 in any mode, and SHALL saturate at 0xFFFF without wrapping.
REQ-022 Simultaneous output drain and input accept SHALL advance the pipeline with no bubble and no sample loss.

Reset
REQ-023 While rst_n is low, out_valid, all stage-valid flags, out_data and sat_count SHALL be 0, and in_ready SHALL be 1 from reset release.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight samples immediately, with no output produced for them after release.

Structure
REQ-025 The shared package tanh_pkg SHALL hold the mode encoding constants (MODE_EXACT, MODE_APPROX, MODE_CLAMP) and the segment thresholds expressed as fractions of ONE.
REQ-026 The combinational PWL core (stage-2 math) SHALL be the sub-module tanh_pwl_core, parametrised by WIDTH, reusable by other activation blocks.

Verification (WIDTH=8, APPROX_LSBS=2, ONE=64)
REQ-027 The bench SHALL drive mode 0 with x = 16, 32, 64, 96, 100 and require y = 16, 32, 48, 64, 64, each appearing 3 cycles after transfer.
REQ-028 The bench SHALL drive mode 0 with x = -128, -45 and require y = -64, -38; in mode 1, x = 45 and -45 SHALL give 36 and -36.
REQ-029 The bench SHALL drive mode 2 with x = 50, -100 and require y = 50, -64.
REQ-030 The bench SHALL hold out_ready low for 5 cycles during a continuous stream, then require in_ready low once the pipe is full, no lost or duplicated samples, and preserved order.
REQ-031 The bench SHALL apply 65540 transfers with x = 127 and require sat_count = 0xFFFF, stable at that value.
REQ-032 The bench SHALL assert rst_n low with 3 samples in flight and require out_valid = 0, sat_count = 0, and no stale output after release.
